// File: rtl/xdma_irq_pkg.sv
// xdma_irq_pkg: shared types and sizes for the XDMA user-interrupt scheduler.
// Holds the FSM encoding and the one-hot to index helper.
package xdma_irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARB      = 2'd1,
    ST_REQ      = 2'd2,
    ST_WAIT_CLR = 2'd3
  } irq_state_e;

  localparam int IRQ_NUM_MAX = 16;
  localparam int PTR_W       = 4;
  localparam int TMO_W       = 20;
  localparam int DROP_W      = 8;

  function automatic logic [PTR_W-1:0] oh2idx(
    input logic [IRQ_NUM_MAX-1:0] oh
  );
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < IRQ_NUM_MAX; i++) begin
      if (oh[i]) idx = PTR_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/xdma_irq_sched_if.sv
// xdma_irq_sched_if: usr_irq_req / usr_irq_ack handshake with the XDMA core.
// master = scheduler side, slave = XDMA core side.
interface xdma_irq_sched_if #(
  parameter int N = 8
) ();

  logic [N-1:0] xdma_irq_req_o;
  logic [N-1:0] xdma_irq_ack_i;

  modport master (
    output xdma_irq_req_o,
    input  xdma_irq_ack_i
  );

  modport slave (
    input  xdma_irq_req_o,
    output xdma_irq_ack_i
  );

endinterface

// File: rtl/irq_rr_pick.sv
// irq_rr_pick: combinational round-robin picker.
// Grants the first set request at or after ptr, wrapping modulo N.
module irq_rr_pick
  import xdma_irq_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic             vld
);

  int idx;

  always_comb begin
    gnt = '0;
    vld = 1'b0;
    idx = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      for (int j = 0; j < N; j++) begin
        if (!vld && j == idx && req[j]) begin
          gnt[j] = 1'b1;
          vld    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/xdma_irq_sched.sv
// xdma_irq_sched: round-robin serialiser of user events onto XDMA usr_irq_req.
// Define IRQ_TIMEOUT_EN to build the ack timeout in the REQ state.
module xdma_irq_sched
  import xdma_irq_pkg::*;
#(
  parameter int IRQ_NUM     = 8,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic               S_AXI_ACLK,
  input  logic               S_AXI_ARESETN,
  input  logic               irq_en_i,
  input  logic [IRQ_NUM-1:0] irq_mask_i,
  input  logic [IRQ_NUM-1:0] user_irq_i,
  input  logic [IRQ_NUM-1:0] irq_clr_i,
  xdma_irq_sched_if.master   xdma,
  output logic [IRQ_NUM-1:0] irq_pending_o,
  output logic [IRQ_NUM-1:0] irq_active_o,
  output logic               irq_busy_o,
  output logic [DROP_W-1:0]  irq_drop_cnt_o,
  output logic               irq_timeout_o
);

  irq_state_e state_q, state_d;

  logic [IRQ_NUM-1:0] prev_q, pend_q, pend_d;
  logic [IRQ_NUM-1:0] grant_q, grant_d;
  logic [IRQ_NUM-1:0] req_q, req_d;
  logic [IRQ_NUM-1:0] act_q, act_d;
  logic [IRQ_NUM-1:0] rise, take, elig;
  logic [IRQ_NUM-1:0] pick_gnt;
  logic               pick_vld;
  logic               busy_q, busy_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d, gidx;
  logic [DROP_W-1:0]  drop_q;
  logic               ack_hit, clr_hit;
  logic               drop_hit, adv, tmo_fire;

  assign rise    = user_irq_i & ~prev_q;
  assign elig    = pend_q & ~irq_mask_i;
  assign ack_hit = |(xdma.xdma_irq_ack_i & grant_q);
  assign clr_hit = |(irq_clr_i & grant_q);
  assign gidx    = oh2idx(IRQ_NUM_MAX'(grant_q));

  irq_rr_pick #(
    .N (IRQ_NUM)
  ) u_pick (
    .req (elig),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .vld (pick_vld)
  );

`ifdef IRQ_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             tmo_q;

  assign tmo_fire = (state_q == ST_REQ) && !ack_hit &&
                    (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));

  // Counter is held at zero outside REQ, so every REQ entry starts fresh.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else if (!irq_en_i) begin
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= (state_q == ST_REQ) ? tmo_cnt_q + 1'b1 : '0;
      tmo_q     <= tmo_fire;
    end
  end

  assign irq_timeout_o = tmo_q;
`else
  logic [TMO_W-1:0] tmo_unused;

  assign tmo_unused    = TMO_W'(TIMEOUT_CYC);
  assign tmo_fire      = 1'b0;
  assign irq_timeout_o = 1'b0;
`endif

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q <= ST_IDLE;
    end else if (!irq_en_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|elig) state_d = ST_ARB;
      end
      ST_ARB: begin
        state_d = pick_vld ? ST_REQ : ST_IDLE;
      end
      ST_REQ: begin
        if (ack_hit)       state_d = ST_WAIT_CLR;
        else if (tmo_fire) state_d = ST_IDLE;
      end
      ST_WAIT_CLR: begin
        if (clr_hit) state_d = ST_IDLE;
      end
    endcase
  end

  // A new rise always wins over clear, take and timeout in the same cycle.
  always_comb begin
    take    = '0;
    grant_d = grant_q;
    if (state_q == ST_ARB && pick_vld) begin
      take    = pick_gnt;
      grant_d = pick_gnt;
    end
    adv   = ((state_q == ST_WAIT_CLR) && clr_hit) || tmo_fire;
    ptr_d = ptr_q;
    if (adv) begin
      ptr_d = (gidx == PTR_W'(IRQ_NUM - 1)) ? '0 : gidx + 1'b1;
    end
    pend_d   = (pend_q & ~irq_clr_i & ~take) | rise |
               (tmo_fire ? grant_q : '0);
    drop_hit = |(rise & pend_q & ~irq_clr_i & ~take);
  end

  always_comb begin
    req_d  = '0;
    act_d  = '0;
    busy_d = (state_d != ST_IDLE);
    if (state_d == ST_REQ) req_d = grant_d;
    if (state_d == ST_REQ || state_d == ST_WAIT_CLR) act_d = grant_d;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      prev_q  <= '0;
      pend_q  <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
      drop_q  <= '0;
      req_q   <= '0;
      act_q   <= '0;
      busy_q  <= 1'b0;
    end else if (!irq_en_i) begin
      prev_q  <= user_irq_i;
      pend_q  <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
      drop_q  <= '0;
      req_q   <= '0;
      act_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      prev_q  <= user_irq_i;
      pend_q  <= pend_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      req_q   <= req_d;
      act_q   <= act_d;
      busy_q  <= busy_d;
      if (drop_hit && drop_q != '1) drop_q <= drop_q + 1'b1;
    end
  end

  assign xdma.xdma_irq_req_o = req_q;
  assign irq_pending_o       = pend_q;
  assign irq_active_o        = act_q;
  assign irq_busy_o          = busy_q;
  assign irq_drop_cnt_o      = drop_q;

endmodule

// File: tb/tb_xdma_irq_sched.sv
// tb_xdma_irq_sched: directed scenarios plus randomized traffic
// checked against a behavioural model of the scheduler.
module tb_xdma_irq_sched;

  localparam int N   = 8;
  localparam int TMO = 100;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         en    = 1'b1;
  logic [N-1:0] mask  = '0;
  logic [N-1:0] usr   = '0;
  logic [N-1:0] clr   = '0;
  logic [N-1:0] ack   = '0;
  logic [N-1:0] req, pend, act;
  logic         busy, tmo;
  logic [7:0]   drop;

  int n_chk = 0;
  int n_err = 0;

  xdma_irq_sched_if #(.N(N)) xif ();
  assign xif.xdma_irq_ack_i = ack;
  assign req = xif.xdma_irq_req_o;

  xdma_irq_sched #(
    .IRQ_NUM     (N),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .S_AXI_ACLK     (clk),
    .S_AXI_ARESETN  (rst_n),
    .irq_en_i       (en),
    .irq_mask_i     (mask),
    .user_irq_i     (usr),
    .irq_clr_i      (clr),
    .xdma           (xif.master),
    .irq_pending_o  (pend),
    .irq_active_o   (act),
    .irq_busy_o     (busy),
    .irq_drop_cnt_o (drop),
    .irq_timeout_o  (tmo)
  );

  always #5 clk = ~clk;

  // Model: 0 idle, 1 arbitrate, 2 request out, 3 waiting for host clear
  bit m_pend[N];
  bit m_prev[N];
  int m_phase;
  int m_grant;
  int m_ptr;
  int m_drop;
  int m_rc;
  bit m_tmo;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0;
      m_prev[i] = 0;
    end
    m_phase = 0;
    m_grant = 0;
    m_ptr   = 0;
    m_drop  = 0;
    m_rc    = 0;
    m_tmo   = 0;
  endfunction

  function automatic void model_step();
    bit rise[N];
    int take, nph, idx;
    bit lost, fire;
    take = -1;
    lost = 0;
    fire = 0;
    m_tmo = 0;
    if (!en) begin
      model_reset();
      for (int i = 0; i < N; i++) m_prev[i] = usr[i];
      return;
    end
    for (int i = 0; i < N; i++) rise[i] = usr[i] && !m_prev[i];
    nph = m_phase;
    case (m_phase)
      0: begin
        for (int i = 0; i < N; i++)
          if (m_pend[i] && !mask[i]) nph = 1;
      end
      1: begin
        nph = 0;
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (take < 0 && m_pend[idx] && !mask[idx]) take = idx;
        end
        if (take >= 0) begin
          m_grant = take;
          m_rc = 0;
          nph = 2;
        end
      end
      2: begin
        if (ack[m_grant]) nph = 3;
`ifdef IRQ_TIMEOUT_EN
        else if (m_rc == TMO - 1) begin
          nph = 0;
          fire = 1;
          m_ptr = (m_grant + 1) % N;
        end else m_rc++;
`endif
      end
      default: begin
        if (clr[m_grant]) begin
          nph = 0;
          m_ptr = (m_grant + 1) % N;
        end
      end
    endcase
    for (int i = 0; i < N; i++) begin
      if (rise[i] && m_pend[i] && !clr[i] && i != take) lost = 1;
      m_pend[i] = (m_pend[i] && !clr[i] && i != take) || rise[i];
      m_prev[i] = usr[i];
    end
    if (fire) m_pend[m_grant] = 1;
    m_tmo = fire;
    if (lost && m_drop < 255) m_drop++;
    m_phase = nph;
  endfunction

  function automatic logic [N-1:0] m_req_vec();
    logic [N-1:0] v;
    v = '0;
    if (m_phase == 2) v[m_grant] = 1'b1;
    return v;
  endfunction

  function automatic logic [N-1:0] m_act_vec();
    logic [N-1:0] v;
    v = '0;
    if (m_phase >= 2) v[m_grant] = 1'b1;
    return v;
  endfunction

  function automatic logic [N-1:0] m_pend_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    else model_step();
  endtask

  task automatic flush();
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
  endtask

  // Host behaviour: wait for a request, ack it, then clear it.
  task automatic serve(output logic [N-1:0] got, output bit multi);
    got = '0;
    multi = 0;
    for (int c = 0; c < 40 && got == '0; c++) begin
      tick();
      if ($countones(req) > 1) multi = 1;
      got = req;
    end
    if (got == '0) return;
    repeat ($urandom_range(0, 3)) tick();
    ack = got;
    tick();
    ack = '0;
    repeat ($urandom_range(0, 3)) tick();
    clr = got;
    tick();
    clr = '0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    tick();
    tick();
    n_chk++;
    if ({req, pend, act, busy, drop, tmo} !== '0) begin
      n_err++;
      $display("FAIL reset_vals got req=%h pend=%h act=%h busy=%b drop=%0d tmo=%b exp all 0",
               req, pend, act, busy, drop, tmo);
    end
    rst_n = 1'b1;
    tick();
    n_chk++;
    if ({req, pend, act, busy, drop, tmo} !== '0) begin
      n_err++;
      $display("FAIL reset_release got req=%h pend=%h busy=%b exp all 0", req, pend, busy);
    end
  endtask

  task automatic test_single();
    logic [N-1:0] got;
    bit multi;
    usr = 8'h08;
    tick();
    n_chk++;
    if (pend !== 8'h08 || req !== 8'h00) begin
      n_err++;
      $display("FAIL single_pend got pend=%h req=%h exp pend=08 req=00", pend, req);
    end
    tick();
    n_chk++;
    if (busy !== 1'b1 || req !== 8'h00) begin
      n_err++;
      $display("FAIL single_arb got busy=%b req=%h exp busy=1 req=00", busy, req);
    end
    tick();
    usr = '0;
    n_chk++;
    if (req !== 8'h08 || act !== 8'h08 || pend !== 8'h00) begin
      n_err++;
      $display("FAIL single_req got req=%h act=%h pend=%h exp 08 08 00", req, act, pend);
    end
    repeat (4) tick();
    ack = 8'h08;
    tick();
    ack = '0;
    n_chk++;
    if (req !== 8'h00 || busy !== 1'b1 || act !== 8'h08) begin
      n_err++;
      $display("FAIL single_ack got req=%h busy=%b act=%h exp 00 1 08", req, busy, act);
    end
    repeat (3) tick();
    clr = 8'h08;
    tick();
    clr = '0;
    n_chk++;
    if (busy !== 1'b0 || act !== 8'h00) begin
      n_err++;
      $display("FAIL single_clr got busy=%b act=%h exp 0 00", busy, act);
    end
    // Pointer now sits at 4: of sources 2 and 5, source 5 goes first
    usr = 8'h24;
    tick();
    usr = '0;
    serve(got, multi);
    n_chk++;
    if (got !== 8'h20) begin
      n_err++;
      $display("FAIL single_ptr got=%h exp=20", got);
    end
    serve(got, multi);
    n_chk++;
    if (got !== 8'h04) begin
      n_err++;
      $display("FAIL single_ptr_wrap got=%h exp=04", got);
    end
  endtask

  task automatic test_multi();
    logic [N-1:0] got;
    logic [N-1:0] exp_q[$];
    bit multi;
    flush();
    exp_q = '{8'h01, 8'h04, 8'h80};
    usr = 8'h85;
    tick();
    usr = '0;
    foreach (exp_q[i]) begin
      serve(got, multi);
      n_chk++;
      if (got !== exp_q[i] || multi) begin
        n_err++;
        $display("FAIL multi_order[%0d] got=%h multi=%0d exp=%h multi=0", i, got, multi, exp_q[i]);
      end
    end
    tick();
    n_chk++;
    if (pend !== 8'h00 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL multi_end got pend=%h busy=%b exp 00 0", pend, busy);
    end
  endtask

  task automatic test_mask();
    logic [N-1:0] got;
    bit multi;
    int seen;
    flush();
    mask = 8'h20;
    usr = 8'h20;
    tick();
    usr = '0;
    seen = 0;
    repeat (8) begin
      tick();
      if (req != '0 || busy) seen++;
    end
    n_chk++;
    if (pend !== 8'h20 || seen != 0) begin
      n_err++;
      $display("FAIL mask_hold got pend=%h active_cycles=%0d exp pend=20 active_cycles=0", pend, seen);
    end
    mask = '0;
    serve(got, multi);
    n_chk++;
    if (got !== 8'h20) begin
      n_err++;
      $display("FAIL mask_release got=%h exp=20", got);
    end
  endtask

  task automatic test_drop();
    flush();
    mask = 8'h02;
    repeat (10) begin
      usr = 8'h02;
      tick();
      usr = '0;
      tick();
    end
    n_chk++;
    if (drop !== 8'd9) begin
      n_err++;
      $display("FAIL drop_count got=%0d exp=9", drop);
    end
    repeat (290) begin
      usr = 8'h02;
      tick();
      usr = '0;
      tick();
    end
    n_chk++;
    if (drop !== 8'd255) begin
      n_err++;
      $display("FAIL drop_sat got=%0d exp=255", drop);
    end
    repeat (5) begin
      usr = 8'h02;
      tick();
      usr = '0;
      tick();
    end
    n_chk++;
    if (drop !== 8'd255 || req !== 8'h00) begin
      n_err++;
      $display("FAIL drop_hold got drop=%0d req=%h exp 255 00", drop, req);
    end
    clr = 8'h02;
    tick();
    clr = '0;
    mask = '0;
    tick();
    n_chk++;
    if (pend !== 8'h00 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL drop_clr got pend=%h busy=%b exp 00 0", pend, busy);
    end
  endtask

  task automatic test_en_flush();
    logic [N-1:0] got;
    bit multi;
    flush();
    usr = 8'h40;
    tick();
    usr = '0;
    tick();
    tick();
    ack = 8'h40;
    tick();
    ack = '0;
    usr = 8'h04;
    tick();
    n_chk++;
    if (busy !== 1'b1 || act !== 8'h40 || pend !== 8'h04) begin
      n_err++;
      $display("FAIL flush_pre got busy=%b act=%h pend=%h exp 1 40 04", busy, act, pend);
    end
    en = 1'b0;
    tick();
    n_chk++;
    if ({req, pend, act, busy, drop, tmo} !== '0) begin
      n_err++;
      $display("FAIL flush_vals got req=%h pend=%h act=%h busy=%b exp all 0", req, pend, act, busy);
    end
    en = 1'b1;
    tick();
    tick();
    n_chk++;
    if (pend !== 8'h00 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL flush_held_level got pend=%h busy=%b exp 00 0", pend, busy);
    end
    usr = '0;
    tick();
    usr = 8'h02;
    tick();
    usr = '0;
    serve(got, multi);
    n_chk++;
    if (got !== 8'h02) begin
      n_err++;
      $display("FAIL flush_resume got=%h exp=02", got);
    end
  endtask

  task automatic test_async_reset();
    logic [N-1:0] got;
    bit multi;
    flush();
    usr = 8'h10;
    tick();
    usr = '0;
    tick();
    tick();
    n_chk++;
    if (req !== 8'h10) begin
      n_err++;
      $display("FAIL areset_pre got req=%h exp=10", req);
    end
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    n_chk++;
    if (req !== 8'h00 || act !== 8'h00 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL areset_now got req=%h act=%h busy=%b exp 00 00 0", req, act, busy);
    end
    tick();
    rst_n = 1'b1;
    usr = 8'h01;
    tick();
    usr = '0;
    serve(got, multi);
    n_chk++;
    if (got !== 8'h01) begin
      n_err++;
      $display("FAIL areset_resume got=%h exp=01", got);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] one;
    one = 1;
    flush();
    for (int c = 0; c < 1500; c++) begin
      usr = usr ^ (N'($urandom) & N'($urandom) & N'($urandom));
      if ($urandom_range(0, 63) == 0) mask = N'($urandom) & N'($urandom);
      ack = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      clr = ($urandom_range(0, 3) == 0) ? (one << $urandom_range(0, N - 1)) : '0;
      en  = ($urandom_range(0, 299) != 0);
      tick();
      n_chk++;
      if (req !== m_req_vec()) begin
        n_err++;
        $display("FAIL rnd_req cyc=%0d got=%h exp=%h", c, req, m_req_vec());
      end
      n_chk++;
      if (pend !== m_pend_vec()) begin
        n_err++;
        $display("FAIL rnd_pend cyc=%0d got=%h exp=%h", c, pend, m_pend_vec());
      end
      n_chk++;
      if (act !== m_act_vec() || busy !== (m_phase != 0)) begin
        n_err++;
        $display("FAIL rnd_act cyc=%0d got act=%h busy=%b exp act=%h busy=%b",
                 c, act, busy, m_act_vec(), m_phase != 0);
      end
      n_chk++;
      if (drop !== 8'(m_drop) || tmo !== m_tmo) begin
        n_err++;
        $display("FAIL rnd_drop cyc=%0d got drop=%0d tmo=%b exp drop=%0d tmo=%b",
                 c, drop, tmo, m_drop, m_tmo);
      end
    end
    usr = '0;
    mask = '0;
    ack = '0;
    clr = '0;
    en = 1'b1;
    flush();
  endtask

`ifdef IRQ_TIMEOUT_EN
  task automatic test_timeout();
    logic [N-1:0] got, r_at, p_at;
    logic b_at;
    bit multi;
    int pulses;
    flush();
    usr = 8'h0C;
    tick();
    usr = '0;
    pulses = 0;
    r_at = '1;
    p_at = '0;
    b_at = 1'b1;
    for (int c = 0; c < 3 * TMO && pulses == 0; c++) begin
      tick();
      if (tmo) begin
        pulses++;
        r_at = req;
        p_at = pend;
        b_at = busy;
      end
    end
    n_chk++;
    if (pulses != 1 || r_at !== 8'h00 || p_at !== 8'h0C || b_at !== 1'b0) begin
      n_err++;
      $display("FAIL tmo_fire got pulses=%0d req=%h pend=%h busy=%b exp 1 00 0c 0",
               pulses, r_at, p_at, b_at);
    end
    tick();
    n_chk++;
    if (tmo !== 1'b0) begin
      n_err++;
      $display("FAIL tmo_pulse_width got tmo=%b exp=0", tmo);
    end
    serve(got, multi);
    n_chk++;
    if (got !== 8'h08) begin
      n_err++;
      $display("FAIL tmo_next got=%h exp=08", got);
    end
    serve(got, multi);
    n_chk++;
    if (got !== 8'h04) begin
      n_err++;
      $display("FAIL tmo_retry got=%h exp=04", got);
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_multi();
    test_mask();
    test_drop();
    test_en_flush();
    test_async_reset();
    test_random();
`ifdef IRQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
